// File: rtl/sub32_serial_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
interface sub32_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;
  logic             Z;

  // Requester side: issues operations and observes results.
  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, V, Z
  );

  // Subtractor side.
  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, V, Z
  );
endinterface

// File: rtl/sub32_serial.sv
// Digit-serial subtractor: D = A - B - Bin, DIGIT bits per clock, LSB digit first,
// borrow carried between digits in a register. Results hold until the next completion.
module sub32_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  sub32_serial_if.slave bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = DIGIT + 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("sub32_serial: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bout_q, bout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic [DIGIT:0]   diff;
  logic             accept;

  // Next-state: operands shift right one digit per cycle, result digits enter from the top.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bout_d   = bout_q;
    v_d      = v_q;
    z_d      = z_q;
    diff     = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - DW'(borrow_q);
    accept   = bus.start && (state_q != S_RUN);

    case (state_q)
      S_RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = (res_q >> DIGIT) | (WIDTH'(diff[DIGIT-1:0]) << (WIDTH - DIGIT));
        borrow_d = diff[DIGIT];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // Last digit holds the operand sign bits in its top position.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          d_d     = res_d;
          bout_d  = diff[DIGIT];
          v_d     = (a_q[DIGIT-1] != b_q[DIGIT-1]) && (res_d[WIDTH-1] != a_q[DIGIT-1]);
          z_d     = (res_d == '0);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d  = S_RUN;
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.Bin;
          cnt_d    = '0;
          res_d    = '0;
          busy_d   = 1'b1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bout_q   <= bout_d;
      v_q      <= v_d;
      z_q      <= z_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
endmodule
